// File: rtl/ktne_bomb_timer.sv
// KTNE bomb countdown timer: BCD M:SS countdown with strike-driven speedup,
// defuse/explode end states and active-low seven-segment digit drive.
module ktne_bomb_timer #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DIGITS      = 3,
    parameter int unsigned START_MIN   = 5,
    parameter int unsigned START_SEC   = 0,
    parameter int unsigned MAX_STRIKES = 3,
    parameter int unsigned SPEEDUP     = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                pause,
    input  logic                strike,
    input  logic                defuse,
    output logic [7*DIGITS-1:0] hex,
    output logic [2:0]          strikes,
    output logic [1:0]          state,
    output logic                tick
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned TW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        DEFUSED  = 2'b10,
        EXPLODED = 2'b11
    } state_t;

    // Start value packed as BCD digits, seconds in the low byte.
    function automatic logic [TW-1:0] start_bcd();
        logic [TW-1:0] v;
        int unsigned   m;
        v      = '0;
        v[3:0] = 4'(START_SEC % 10);
        v[7:4] = 4'(START_SEC / 10);
        m      = START_MIN;
        for (int i = 2; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(m % 10);
            m           = m / 10;
        end
        return v;
    endfunction

    // One-second BCD decrement; seconds tens borrow through 5, saturates at zero.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        logic          borrow;
        r      = t;
        borrow = (t != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (t[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam logic [TW-1:0] START_BCD = start_bcd();

    state_t        st;
    logic [TW-1:0] time_bcd;
    logic [PW-1:0] prescaler;
    logic [31:0]   period;
    logic [TW-1:0] time_dec;
    logic [2:0]    strikes_inc;
    logic          fatal_strike;
    logic          zero_next;

    // Tick period shrinks by a power of two per strike, never below one cycle.
    always_comb begin
        period = (SPEEDUP != 0) ? (CLK_HZ >> strikes) : CLK_HZ;
        if (period == 32'd0) begin
            period = 32'd1;
        end
    end

    assign tick         = (st == RUN) && !pause && (32'(prescaler) >= period - 32'd1);
    assign time_dec     = bcd_dec(time_bcd);
    assign strikes_inc  = (32'(strikes) < MAX_STRIKES) ? strikes + 3'd1 : strikes;
    assign fatal_strike = strike && (32'(strikes_inc) == MAX_STRIKES);
    assign zero_next    = tick && (time_dec == '0);
    assign state        = st;

    // Game FSM; explosion outranks defuse when both land in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            st        <= IDLE;
            time_bcd  <= START_BCD;
            prescaler <= '0;
            strikes   <= '0;
        end else begin
            case (st)
                IDLE: begin
                    time_bcd  <= START_BCD;
                    prescaler <= '0;
                    strikes   <= '0;
                    if (start) begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        prescaler <= '0;
                        time_bcd  <= time_dec;
                    end else if (!pause) begin
                        prescaler <= prescaler + PW'(1);
                    end
                    if (strike) begin
                        strikes <= strikes_inc;
                    end
                    if (zero_next || fatal_strike) begin
                        st <= EXPLODED;
                    end else if (defuse) begin
                        st <= DEFUSED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Display decode; an exploded bomb shows dashes on every digit.
    always_comb begin
        hex = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex[7*i +: 7] = (st == EXPLODED) ? 7'b0111111 : seg7(time_bcd[4*i +: 4]);
        end
    end

endmodule
